// File: rtl/quad_pkg.sv
// Shared phase constants, direction encoding and the phase-step decoder used by quad_step_decoder.
package quad_pkg;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2,
      DIR_ERR  = 2'd3
   } quad_dir_e;

   // Classifies one A/B sample pair; a two-bit change is an illegal jump.
   function automatic quad_dir_e quad_dir(input logic [1:0] prev, input logic [1:0] cur);
      quad_dir_e d;
      d = DIR_NONE;
      if (prev != cur) begin
         case ({prev, cur})
            {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: d = DIR_UP;
            {PH_01, PH_00}, {PH_11, PH_01}, {PH_10, PH_11}, {PH_00, PH_10}: d = DIR_DN;
            default:                                                        d = DIR_ERR;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Input synchroniser with an optional debounce stage (enabled by defining QUAD_DEBOUNCE_EN).
// valid rises once the chain holds a real post-reset sample, so the reset zeros are never decoded.
module quad_sync_filter #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DEBOUNCE_W      = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic valid
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] vld_q;
   logic                   sync_out;
   logic                   sync_vld;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         vld_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign sync_vld = vld_q[SYNC_STAGES-1];

`ifdef QUAD_DEBOUNCE_EN
   logic                  filt_q;
   logic                  filt_vld_q;
   logic [DEBOUNCE_W-1:0] cnt_q;

   // The first real sample is taken as-is; after that a change needs a full stable run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_q     <= 1'b0;
         filt_vld_q <= 1'b0;
         cnt_q      <= '0;
      end else if (!filt_vld_q) begin
         cnt_q <= '0;
         if (sync_vld) begin
            filt_q     <= sync_out;
            filt_vld_q <= 1'b1;
         end
      end else if (sync_out != filt_q) begin
         if (cnt_q == DEBOUNCE_W'(DEBOUNCE_CYCLES - 1)) begin
            filt_q <= sync_out;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else begin
         cnt_q <= '0;
      end
   end

   assign dout  = filt_q;
   assign valid = filt_vld_q;
`else
   logic unused_debounce_cfg;

   assign unused_debounce_cfg = ^{DEBOUNCE_CYCLES, DEBOUNCE_W};
   assign dout                = sync_out;
   assign valid               = sync_vld;
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B/index decoder producing registered up/down/load strobes for a 4-bit counter.
// Define QUAD_DEBOUNCE_EN to insert the debounce filter on every synchronised input.
module quad_step_decoder
   import quad_pkg::*;
#(
   parameter int                 SYNC_STAGES     = 2,
   parameter int                 DEBOUNCE_CYCLES = 4,
   parameter int                 DEBOUNCE_W      = 3,
   parameter int                 VALUE_W         = 4,
   parameter logic [VALUE_W-1:0] HOME_VALUE      = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enc_a,
   input  logic               enc_b,
   input  logic               enc_idx,
   input  logic               err_clr,
   output logic               up,
   output logic               down,
   output logic               load,
   output logic [VALUE_W-1:0] value,
   output logic               err
);

   logic a_f, b_f, idx_f;
   logic a_v, b_v, idx_v;

   quad_sync_filter #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEBOUNCE_W(DEBOUNCE_W)
   ) u_filt_a (
      .clk(clk), .reset(reset), .din(enc_a), .dout(a_f), .valid(a_v)
   );

   quad_sync_filter #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEBOUNCE_W(DEBOUNCE_W)
   ) u_filt_b (
      .clk(clk), .reset(reset), .din(enc_b), .dout(b_f), .valid(b_v)
   );

   quad_sync_filter #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEBOUNCE_W(DEBOUNCE_W)
   ) u_filt_idx (
      .clk(clk), .reset(reset), .din(enc_idx), .dout(idx_f), .valid(idx_v)
   );

   logic [1:0]         prev_ab_q, prev_ab_d;
   logic               primed_q, primed_d;
   logic               idx_q, idx_d;
   logic               up_q, up_d;
   logic               down_q, down_d;
   logic               load_q, load_d;
   logic               err_q, err_d;
   logic [VALUE_W-1:0] value_q;

   logic               sample_valid;
   logic [1:0]         cur_ab;
   logic               idx_rise;
   quad_dir_e          dir;

   assign sample_valid = a_v & b_v & idx_v;
   assign cur_ab       = {a_f, b_f};
   assign idx_rise     = idx_f & ~idx_q;
   assign dir          = quad_dir(prev_ab_q, cur_ab);

   // The first valid sample only primes history; a load drops any coincident step.
   always_comb begin
      prev_ab_d = prev_ab_q;
      primed_d  = primed_q;
      idx_d     = idx_q;
      up_d      = 1'b0;
      down_d    = 1'b0;
      load_d    = 1'b0;
      err_d     = err_q;
      if (err_clr) err_d = 1'b0;
      if (sample_valid) begin
         prev_ab_d = cur_ab;
         idx_d     = idx_f;
         primed_d  = 1'b1;
         if (primed_q) begin
            load_d = idx_rise;
            if (dir == DIR_ERR) begin
               err_d = 1'b1;
            end else if (!idx_rise) begin
               up_d   = (dir == DIR_UP);
               down_d = (dir == DIR_DN);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_ab_q <= PH_00;
         primed_q  <= 1'b0;
         idx_q     <= 1'b0;
         up_q      <= 1'b0;
         down_q    <= 1'b0;
         load_q    <= 1'b0;
         err_q     <= 1'b0;
         value_q   <= HOME_VALUE;
      end else begin
         prev_ab_q <= prev_ab_d;
         primed_q  <= primed_d;
         idx_q     <= idx_d;
         up_q      <= up_d;
         down_q    <= down_d;
         load_q    <= load_d;
         err_q     <= err_d;
         value_q   <= HOME_VALUE;
      end
   end

   assign up    = up_q;
   assign down  = down_q;
   assign load  = load_q;
   assign err   = err_q;
   assign value = value_q;

endmodule
